// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the parity-RAM request controller.
// Holds the FSM state encoding, default bus widths and the parity rule.
package mem_ctrl_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      WAIT,
      RSP
   } mem_ctrl_state_e;

   // Even-XOR parity: a stored word {calc_par(d), d} is clean.
   function automatic logic calc_par(input logic [DATA_W_DEF-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Sequences single-beat read/write requests into the parity RAM; a read response appears 1+RD_LAT cycles after accept.
// One request in flight: req_ready is low until a write retires or a read response is taken.
module mem_req_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int RD_LAT    = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DATA_W-1:0]    req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_W-1:0]    rsp_data,
   output logic [ADDR_W-1:0]    rsp_addr,
   output logic                 rsp_perr,
   output logic                 mem_write,
   output logic                 mem_read,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_din,
   input  logic [DATA_W:0]      mem_dout,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int CNT_W = 3;

   mem_ctrl_state_e  state_q, state_d;
   logic [CNT_W-1:0] lat_cnt;
   logic             accept;
   logic             capture;
   logic             rd_perr;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;
   assign capture   = (state_q == WAIT) && (lat_cnt == '0);
   assign rd_perr   = (^mem_dout[DATA_W-1:0]) != mem_dout[DATA_W];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = req_write ? WR : RD;
         WR:      state_d = IDLE;
         RD:      state_d = WAIT;
         WAIT:    if (lat_cnt == '0) state_d = RSP;
         RSP:     if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Strobes are derived from accept, which only fires in IDLE, so each lasts one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         lat_cnt   <= '0;
      end else begin
         mem_write <= accept && req_write;
         mem_read  <= accept && !req_write;
         if (accept) begin
            mem_addr <= req_addr;
            if (req_write) mem_din <= req_wdata;
         end
         if (state_q == RD)
            lat_cnt <= CNT_W'(RD_LAT - 1);
         else if ((state_q == WAIT) && (lat_cnt != '0))
            lat_cnt <= lat_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_addr  <= '0;
         rsp_perr  <= 1'b0;
         err_count <= '0;
      end else begin
         if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem_dout[DATA_W-1:0];
            rsp_addr  <= mem_addr;
            rsp_perr  <= rd_perr;
            if (rd_perr && (err_count != '1))
               err_count <= err_count + ERR_CNT_W'(1);
         end else if ((state_q == RSP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural parity RAM and a forced bad-word override.
module tb_mem_req_ctrl;
   import mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic [15:0] rsp_addr;
   logic        rsp_perr;
   logic        mem_write;
   logic        mem_read;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic [8:0]  mem_dout;
   logic [1:0]  err_count;

   logic [8:0]  ram [0:65535];
   logic [8:0]  ram_q;
   logic        force_bad;
   logic [8:0]  bad_word;

   int checks = 0;
   int errors = 0;

   mem_req_ctrl #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1), .ERR_CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_perr(rsp_perr),
      .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .err_count(err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) ram[mem_addr] <= {calc_par(mem_din), mem_din};
      if (mem_read)  ram_q <= ram[mem_addr];
   end

   assign mem_dout = force_bad ? bad_word : ram_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
      chk("wr_ready_idle", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("wr_mem_write", mem_write, 1);
      chk("wr_mem_addr", mem_addr, a);
      chk("wr_mem_din", mem_din, d);
      chk("wr_busy", req_ready, 0);
      @(negedge clk);
      chk("wr_pulse_end", mem_write, 0);
      chk("wr_ready_back", req_ready, 1);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [7:0] d, input logic p,
                          input logic [1:0] ec, input int hold);
      rsp_ready = (hold == 0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      chk("rd_ready_idle", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_mem_read", mem_read, 1);
      chk("rd_mem_addr", mem_addr, a);
      chk("rd_busy0", req_ready, 0);
      @(negedge clk);
      chk("rd_pulse_end", mem_read, 0);
      chk("rd_rsp_early", rsp_valid, 0);
      chk("rd_busy1", req_ready, 0);
      @(negedge clk);
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_data", rsp_data, d);
      chk("rd_rsp_addr", rsp_addr, a);
      chk("rd_rsp_perr", rsp_perr, p);
      chk("rd_err_count", err_count, ec);
      chk("rd_busy2", req_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, d);
         chk("hold_addr", rsp_addr, a);
         chk("hold_perr", rsp_perr, p);
         chk("hold_busy", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rd_rsp_done", rsp_valid, 0);
      chk("rd_ready_back", req_ready, 1);
   endtask

   initial begin
      logic [15:0] wa [6];
      logic [7:0]  wd [6];

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b1; force_bad = 1'b0; bad_word = {~calc_par(8'h03), 8'h03};
      #12;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_addr", rsp_addr, 0);
      chk("rst_rsp_perr", rsp_perr, 0);
      chk("rst_err_count", err_count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_write(16'h1234, 8'hA5);
      do_read(16'h1234, 8'hA5, 1'b0, 2'd0, 0);

      do_write(16'h0000, 8'h5C);
      do_write(16'hFFFF, 8'hE7);
      do_read(16'h0000, 8'h5C, 1'b0, 2'd0, 0);
      do_read(16'hFFFF, 8'hE7, 1'b0, 2'd0, 0);

      for (int i = 0; i < 6; i++) begin
         wa[i] = 16'(i * 16'h2000 + 16'h0100 + $urandom_range(0, 16'h1E00));
         wd[i] = 8'($urandom_range(0, 255));
         do_write(wa[i], wd[i]);
      end
      for (int i = 0; i < 6; i++) do_read(wa[i], wd[i], 1'b0, 2'd0, 0);

      force_bad = 1'b1;
      do_read(16'h0042, 8'h03, 1'b1, 2'd1, 0);
      force_bad = 1'b0;
      do_read(16'h1234, 8'hA5, 1'b0, 2'd1, 0);

      do_read(16'h1234, 8'hA5, 1'b0, 2'd1, 5);

      // Reset during a write pulse drops mem_write at once.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0555; req_wdata = 8'h11;
      @(negedge clk);
      req_valid = 1'b0;
      chk("wrrst_pre", mem_write, 1);
      rst = 1'b1;
      #1;
      chk("wrrst_mem_write", mem_write, 0);
      chk("wrrst_ready", req_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset during WAIT discards the in-flight read.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rdrst_pre_busy", req_ready, 0);
      rst = 1'b1;
      #1;
      chk("rdrst_mem_read", mem_read, 0);
      chk("rdrst_rsp_valid", rsp_valid, 0);
      chk("rdrst_ready", req_ready, 1);
      chk("rdrst_err_count", err_count, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rdrst_no_rsp", rsp_valid, 0);
         chk("rdrst_idle", req_ready, 1);
      end

      force_bad = 1'b1;
      for (int k = 0; k < 5; k++)
         do_read(16'h0042, 8'h03, 1'b1, (k < 3) ? 2'(k + 1) : 2'd3, 0);
      force_bad = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
